// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO over a simple dual-port memory.
// Tracks occupancy, threshold flags and sticky overflow/underflow status.
module sync_fifo_mem #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int AFULL_TH  = 2**ADDR_W - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AEMPTY_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_evt;
  logic              udf_evt;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A read frees a slot this edge, so a write at full still fits.
  assign rd_acc  = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign ovf_evt = wr_en && full && !rd_acc;
  assign udf_evt = rd_en && empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_evt)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

endmodule
